fifo: RTL and testbench
=======================

Name: fifo

Overview:
Single-clock synchronous FIFO with registered read data and full/empty status flags. It buffers byte-wide data between a producer and a consumer in the same clock domain. Storage is a register array addressed by binary read/write pointers; status is derived from the pointers.

Parameters:
DATA_WIDTH, 8, width of DATAIN/DATAOUT in bits
DEPTH, 8, number of entries; must be a power of two and at least 2
ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, not overridden by users

Ports:
clock  input  1  rising-edge clock for all state
reset  input  1  asynchronous active-low reset (0 = reset asserted)
wn  input  1  write request; sampled on rising clock edge
rn  input  1  read request; sampled on rising clock edge
DATAIN  input  DATA_WIDTH  write data, captured when a write is accepted
DATAOUT  output  DATA_WIDTH  registered read data
full  output  1  high when DEPTH entries are stored
empty  output  1  high when 0 entries are stored

Behaviour:
- Reset (reset=0, asynchronous, applied immediately): write and read pointers = 0; DATAOUT = 0; empty = 1; full = 0. Memory contents are not reset. Normal operation resumes on the first rising edge after reset returns to 1.
- Pointers are ADDR_WIDTH+1 bits wide. The low bits index memory and the MSB is a wrap bit.
  - empty when wr_ptr == rd_ptr.
  - full when the low bits are equal and the MSBs differ.
  - Both flags decode combinationally from the registered pointers, so they change in the same cycle as the pointer update with no extra latency.
- Write accepted iff wn=1 and full=0: mem[wr_ptr low bits] <= DATAIN, then wr_ptr increments.
- Read accepted iff rn=1 and empty=0: DATAOUT <= mem[rd_ptr low bits], then rd_ptr increments.
  - Read latency is 1 cycle: the data is valid on DATAOUT after the accepting edge.
- DATAOUT holds its last value when no read is accepted, including reads attempted while empty.
- A write while full is ignored: memory and pointers are unchanged.
- A read while empty is ignored: the pointer and DATAOUT are unchanged.
- Simultaneous wn=1 and rn=1:
  - Each is accepted independently per the rules above, using flag values from before the edge.
  - When neither flag is set, both complete and occupancy is unchanged.
  - When full, only the read completes.
  - When empty, only the write completes; DATAOUT is not updated and there is no write-through bypass.
- Pointers wrap naturally modulo 2*DEPTH. FIFO order is preserved across wrap-around.
- X on wn or rn is not a supported input.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined: two extra outputs are added, overflow (1 bit) and underflow (1 bit).
  - overflow is set on an edge where wn=1 and full=1.
  - underflow is set on an edge where rn=1 and empty=1.
  - Both are sticky until reset and are cleared to 0 by reset.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package fifo_pkg holds the DATA_WIDTH and DEPTH default constants and a typedef for the data word.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH register array with one synchronous write port and one synchronous registered read port. It has no reset on the array and is instantiated once.
- Pointer, flag, and error-flag logic stays in fifo.

Test Plan:
- Reset then idle: reset=0 for 1 cycle, then 1 -> DATAOUT=0, empty=1, full=0.
- Write 100,150,200,40,70,65,15 (wn=1, rn=0), then 7 reads (wn=0, rn=1) -> DATAOUT after each read edge = 100,150,200,40,70,65,15 in order; after the 7th read empty=1; one extra read leaves DATAOUT=15.
- Write 8 values 1..8 -> full=1 after the 8th edge; a 9th write of 99 is ignored; reading 8 times returns 1..8, then empty=1. With FIFO_ERR_FLAGS_EN, overflow=1 after the 9th write.
- Wrap-around: write 6, read 6, write 8, read 8 -> values return in order across the pointer wrap; full and empty assert at the correct counts.
- Simultaneous wn=rn=1 with 3 entries stored for 5 cycles -> occupancy stays 3; outputs are the stored values in order followed by the new writes; flags stay 0/0.
- Async reset mid-operation: with 4 entries stored, pulse reset=0 between clock edges -> empty=1, full=0, and DATAOUT=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and data-word type for the single-clock FIFO.
// Optional error flags are enabled by defining FIFO_ERR_FLAGS_EN.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// registered read port. Only the read register is reset, never the array.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Storage array write port; contents are intentionally left unreset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule : fifo_mem

// File: rtl/fifo.sv
// Single-clock synchronous FIFO with registered read data and full/empty flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int DEPTH      = FIFO_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wn,
  input  logic                  rn,
  input  logic [DATA_WIDTH-1:0] DATAIN,
  output logic [DATA_WIDTH-1:0] DATAOUT,
  output logic                  full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty
);

  localparam int              PTR_W   = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             rd_en_s;

  // Flags decode straight from the registered pointers; the MSB is the wrap bit.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
              (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]);
    wr_en_s = wn && !full_s;
    rd_en_s = rn && !empty_s;
  end

  // Pointer registers, advancing only on accepted transfers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (wr_en_s),
    .waddr (wr_ptr_r[ADDR_WIDTH-1:0]),
    .wdata (DATAIN),
    .re    (rd_en_s),
    .raddr (rd_ptr_r[ADDR_WIDTH-1:0]),
    .rdata (DATAOUT)
  );

  assign full  = full_s;
  assign empty = empty_s;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags for rejected requests; cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wn && full_s) begin
        overflow_r <= 1'b1;
      end
      if (rn && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule : fifo

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wn    = 1'b0;
  logic       rn    = 1'b0;
  logic [7:0] DATAIN = 8'd0;
  logic [7:0] DATAOUT;
  logic       full;
  logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
  bit         ovf_m = 1'b0;
  bit         unf_m = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q [$];
  logic [7:0] dout_m = 8'd0;

  fifo dut (
    .clock     (clock),
    .reset     (reset),
    .wn        (wn),
    .rn        (rn),
    .DATAIN    (DATAIN),
    .DATAOUT   (DATAOUT),
    .full      (full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_dataout"}, 32'(DATAOUT), 32'(dout_m));
    check_eq({tag, "_full"},    32'(full),    32'(model_q.size() == DEPTH));
    check_eq({tag, "_empty"},   32'(empty),   32'(model_q.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
    check_eq({tag, "_overflow"},  32'(overflow),  32'(ovf_m));
    check_eq({tag, "_underflow"}, 32'(underflow), 32'(unf_m));
`endif
  endtask

  // One clock cycle: drive at the falling edge, update model, sample 1 after rising edge.
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
    bit acc_w;
    bit acc_r;
    wn = w; rn = r; DATAIN = d;
    acc_w = w && (model_q.size() < DEPTH);
    acc_r = r && (model_q.size() != 0);
`ifdef FIFO_ERR_FLAGS_EN
    if (w && model_q.size() == DEPTH) ovf_m = 1'b1;
    if (r && model_q.size() == 0)     unf_m = 1'b1;
`endif
    @(posedge clock);
    if (acc_r) dout_m = model_q.pop_front();
    if (acc_w) model_q.push_back(d);
    #1;
    check_outputs(tag);
    @(negedge clock);
    wn = 1'b0; rn = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    dout_m = 8'd0;
`ifdef FIFO_ERR_FLAGS_EN
    ovf_m = 1'b0;
    unf_m = 1'b0;
`endif
  endtask

  logic [7:0] seq7 [7] = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

  initial begin
    // Reset held, then released away from the rising edge.
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst_dataout", 32'(DATAOUT), 32'd0);
    check_eq("rst_empty",   32'(empty),   32'd1);
    check_eq("rst_full",    32'(full),    32'd0);
    reset = 1'b1;
    @(negedge clock);
    step("idle", 1'b0, 1'b0, 8'd0);

    // Seven writes then seven reads, plus an extra read while empty.
    for (int i = 0; i < 7; i++) step("seq_wr", 1'b1, 1'b0, seq7[i]);
    for (int i = 0; i < 7; i++) begin
      step("seq_rd", 1'b0, 1'b1, 8'd0);
      check_eq("seq_rd_value", 32'(DATAOUT), 32'(seq7[i]));
    end
    check_eq("seq_empty", 32'(empty), 32'd1);
    step("extra_rd", 1'b0, 1'b1, 8'd0);
    check_eq("extra_rd_hold", 32'(DATAOUT), 32'd15);

    // Fill to full, attempt an overflow write, drain.
    for (int i = 1; i <= 8; i++) step("fill_wr", 1'b1, 1'b0, 8'(i));
    check_eq("fill_full", 32'(full), 32'd1);
    step("ovf_wr", 1'b1, 1'b0, 8'd99);
`ifdef FIFO_ERR_FLAGS_EN
    check_eq("ovf_flag", 32'(overflow), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      step("fill_rd", 1'b0, 1'b1, 8'd0);
      check_eq("fill_rd_value", 32'(DATAOUT), 32'(i));
    end
    check_eq("drain_empty", 32'(empty), 32'd1);

    // Wrap-around: pointers cross the end of the array.
    for (int i = 0; i < 6; i++) step("wrap_wr6", 1'b1, 1'b0, 8'(8'd20 + 8'(i)));
    for (int i = 0; i < 6; i++) step("wrap_rd6", 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 8; i++) step("wrap_wr8", 1'b1, 1'b0, 8'(8'd40 + 8'(i)));
    for (int i = 0; i < 8; i++) step("wrap_rd8", 1'b0, 1'b1, 8'd0);

    // Simultaneous read/write with three entries stored.
    for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, 1'b0, 8'(8'd60 + 8'(i)));
    for (int i = 0; i < 5; i++) begin
      step("sim_rw", 1'b1, 1'b1, 8'(8'd70 + 8'(i)));
      check_eq("sim_occupancy", 32'(model_q.size()), 32'd3);
    end
    check_eq("sim_last_value", 32'(DATAOUT), 32'd71);

    // Asynchronous reset between edges with four entries stored.
    while (model_q.size() != 0) step("ar_clear", 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 5; i++) step("ar_wr", 1'b1, 1'b0, 8'(8'd80 + 8'(i)));
    step("ar_rd", 1'b0, 1'b1, 8'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_dataout", 32'(DATAOUT), 32'd0);
    check_eq("ar_empty",   32'(empty),   32'd1);
    check_eq("ar_full",    32'(full),    32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step("ar_post", 1'b0, 1'b0, 8'd0);

    // Randomized traffic with alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp;
      wp = ((i / 150) % 2 == 0) ? 32'd75 : 32'd25;
      step("rand", 1'($urandom_range(99) < wp), 1'($urandom_range(99) >= wp),
           8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo
